// File: rtl/screen_arbiter.sv
// Arbitrates the single-port screen BRAM between CPU word accesses and
// 32-word scanline prefetches into the line buffer; fetches take priority.
module screen_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int LINE_WORDS = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    input  logic              line_req,
    input  logic [7:0]        line_num,
    output logic              line_busy,
    output logic              line_done,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              lb_we,
    output logic [4:0]        lb_addr,
    output logic [15:0]       lb_wdata
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CPU_WR,
        CPU_RD,
        CPU_RDW,
        CPU_ACK,
        FETCH,
        DRAIN
    } state_t;

    state_t              state_reg;
    logic                pend_reg;
    logic [7:0]          pend_line_reg;
    logic [7:0]          fetch_line_reg;
    logic [WORD_W-1:0]   word_reg;
    logic                ovr_reg;
    logic                cpu_ack_reg;
    logic [15:0]         cpu_rdata_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic                mem_we_reg;
    logic [15:0]         mem_wdata_reg;
    logic                lb_we_reg;
    logic [WORD_W-1:0]   lb_addr_reg;
    logic                line_done_reg;

    logic                start_fetch;
    logic [7:0]          start_line;
    logic [WORD_W-1:0]   word_inc;

    // A line_req arriving in the very IDLE cycle is fetched directly, so the
    // CPU request seen in that same cycle loses.
    always_comb begin
        start_fetch = (state_reg == IDLE) && (pend_reg || line_req);
        start_line  = line_req ? line_num : pend_line_reg;
        word_inc    = word_reg + WORD_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            pend_reg       <= 1'b0;
            pend_line_reg  <= '0;
            fetch_line_reg <= '0;
            word_reg       <= '0;
            ovr_reg        <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            cpu_rdata_reg  <= '0;
            mem_addr_reg   <= '0;
            mem_we_reg     <= 1'b0;
            mem_wdata_reg  <= '0;
            lb_we_reg      <= 1'b0;
            lb_addr_reg    <= '0;
            line_done_reg  <= 1'b0;
        end else begin
            cpu_ack_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            lb_we_reg     <= 1'b0;
            line_done_reg <= 1'b0;

            if (line_req) begin
                pend_line_reg <= line_num;
            end

            if (start_fetch) begin
                pend_reg <= 1'b0;
            end else if (line_req) begin
                pend_reg <= 1'b1;
            end

            // A request that lands on a not-yet-started fetch discards it.
            if (line_req && pend_reg) begin
                ovr_reg <= 1'b1;
            end else if (ovr_clr) begin
                ovr_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (start_fetch) begin
                        state_reg      <= FETCH;
                        fetch_line_reg <= start_line;
                        word_reg       <= '0;
                        mem_addr_reg   <= ADDR_W'({start_line, {WORD_W{1'b0}}});
                        mem_wdata_reg  <= '0;
                    end else if (cpu_req) begin
                        mem_addr_reg <= cpu_addr;
                        if (cpu_we) begin
                            state_reg     <= CPU_WR;
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= cpu_wdata;
                            cpu_ack_reg   <= 1'b1;
                        end else begin
                            state_reg     <= CPU_RD;
                            mem_wdata_reg <= '0;
                        end
                    end
                end
                CPU_WR: begin
                    state_reg     <= IDLE;
                    mem_addr_reg  <= '0;
                    mem_wdata_reg <= '0;
                end
                CPU_RD: begin
                    state_reg    <= CPU_RDW;
                    mem_addr_reg <= '0;
                end
                CPU_RDW: begin
                    state_reg     <= CPU_ACK;
                    cpu_rdata_reg <= mem_rdata;
                    cpu_ack_reg   <= 1'b1;
                end
                CPU_ACK: begin
                    state_reg <= IDLE;
                end
                FETCH: begin
                    // Line-buffer writes trail the address by the BRAM latency.
                    lb_we_reg   <= 1'b1;
                    lb_addr_reg <= word_reg;
                    if (word_reg == LAST_WORD) begin
                        state_reg     <= DRAIN;
                        line_done_reg <= 1'b1;
                        mem_addr_reg  <= '0;
                    end else begin
                        word_reg     <= word_inc;
                        mem_addr_reg <= ADDR_W'({fetch_line_reg, word_inc});
                    end
                end
                DRAIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign line_busy = pend_reg || (state_reg == FETCH) || (state_reg == DRAIN);
    assign line_done = line_done_reg;
    assign overrun   = ovr_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign mem_wdata = mem_wdata_reg;
    assign lb_we     = lb_we_reg;
    assign lb_addr   = 5'(lb_addr_reg);
    assign lb_wdata  = lb_we_reg ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_screen_arbiter.sv
// Scoreboard bench for screen_arbiter: BRAM model, line-buffer monitor and
// per-scenario tasks checking CPU timing, fetch timing, overrun and reset.
module tb_screen_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [12:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        line_req;
    logic [7:0]  line_num;
    logic        line_busy, line_done, overrun, ovr_clr;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        lb_we;
    logic [4:0]  lb_addr;
    logic [15:0] lb_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } lb_exp_t;

    lb_exp_t     lb_q[$];
    logic [15:0] cpu_q[$];

    // BRAM model: unwritten word n reads back as n.
    bit          bram_written[0:8191];
    logic [15:0] bram_store[0:8191];
    bit          ref_written[0:8191];
    logic [15:0] ref_store[0:8191];

    always #5 clk = ~clk;

    screen_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .line_req(line_req), .line_num(line_num), .line_busy(line_busy),
        .line_done(line_done), .overrun(overrun), .ovr_clr(ovr_clr),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata)
    );

    always @(posedge clk) begin
        if (mem_we) begin
            bram_store[mem_addr]   <= mem_wdata;
            bram_written[mem_addr] <= 1'b1;
        end
        mem_rdata <= bram_written[mem_addr] ? bram_store[mem_addr] : {3'b000, mem_addr};
    end

    function automatic logic [15:0] ref_val(input logic [12:0] a);
        return ref_written[a] ? ref_store[a] : {3'b000, a};
    endfunction

    task automatic push_line(input logic [7:0] n);
        for (int w = 0; w < 32; w++) begin
            lb_exp_t e;
            e.a = 5'(w);
            e.d = ref_val({n, 5'(w)});
            lb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && lb_we === 1'b1) begin
            total_cnt++;
            if (lb_q.size() == 0) begin
                $display("FAIL lb_unexpected: got addr=%0d data=%h, required no write", lb_addr, lb_wdata);
            end else begin
                lb_exp_t e;
                e = lb_q.pop_front();
                if (lb_addr !== e.a || lb_wdata !== e.d)
                    $display("FAIL lb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             lb_addr, lb_wdata, e.a, e.d);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        line_req = 0; line_num = '0; ovr_clr = 0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({cpu_ack, mem_we, lb_we, line_busy, line_done, overrun} !== 6'b0 ||
            mem_addr !== 13'h0 || cpu_rdata !== 16'h0 || lb_wdata !== 16'h0)
            $display("FAIL reset_state: got ctl=%b addr=%h rdata=%h, required all 0",
                     {cpu_ack, mem_we, lb_we, line_busy, line_done, overrun}, mem_addr, cpu_rdata);
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_write_read();
        int ack_k;
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0005; cpu_wdata = 16'hA5A5;
        ref_store[13'h0005] = 16'hA5A5; ref_written[13'h0005] = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (mem_we !== 1'b1 || mem_addr !== 13'h0005 || mem_wdata !== 16'hA5A5 || cpu_ack !== 1'b1)
            $display("FAIL write_t1: got we=%b addr=%h data=%h ack=%b, required 1 0005 a5a5 1",
                     mem_we, mem_addr, mem_wdata, cpu_ack);
        else pass_cnt++;
        cpu_req = 0; cpu_we = 0;
        @(negedge clk);
        total_cnt++;
        if (mem_we !== 1'b0 || cpu_ack !== 1'b0)
            $display("FAIL write_t2: got we=%b ack=%b, required 0 0", mem_we, cpu_ack);
        else pass_cnt++;

        cpu_req = 1; cpu_addr = 13'h0005; cpu_q.push_back(ref_val(13'h0005));
        ack_k = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total_cnt++;
                if (mem_addr !== 13'h0005 || mem_we !== 1'b0)
                    $display("FAIL read_addr: got addr=%h we=%b, required 0005 0", mem_addr, mem_we);
                else pass_cnt++;
            end
            if (cpu_ack === 1'b1 && ack_k == 0) begin
                logic [15:0] exp_d;
                ack_k = k; cpu_req = 0;
                exp_d = cpu_q.pop_front();
                total_cnt++;
                if (cpu_rdata !== exp_d)
                    $display("FAIL read_data: got %h, required %h", cpu_rdata, exp_d);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (ack_k != 3) $display("FAIL read_ack_cycle: got %0d, required 3", ack_k);
        else pass_cnt++;
    endtask

    task automatic test_line_fetch();
        int done_k;
        bit we_seen;
        done_k = 0; we_seen = 0;
        line_req = 1; line_num = 8'd3; push_line(8'd3);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                line_req = 0;
                total_cnt++;
                if (line_busy !== 1'b1 || mem_addr !== 13'h0060)
                    $display("FAIL fetch_start: got busy=%b addr=%h, required 1 0060", line_busy, mem_addr);
                else pass_cnt++;
            end
            if (mem_we === 1'b1) we_seen = 1;
            if (line_done === 1'b1 && done_k == 0) done_k = k;
        end
        total_cnt++;
        if (done_k != 33) $display("FAIL fetch_done_cycle: got %0d, required 33", done_k);
        else pass_cnt++;
        total_cnt++;
        if (lb_q.size() != 0 || we_seen || line_busy !== 1'b0)
            $display("FAIL fetch_end: got left=%0d mem_we_seen=%0d busy=%b, required 0 0 0",
                     lb_q.size(), we_seen, line_busy);
        else pass_cnt++;
    endtask

    task automatic test_fetch_priority();
        int done_k, ack_k;
        done_k = 0; ack_k = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0123; cpu_q.push_back(ref_val(13'h0123));
        line_req = 1; line_num = 8'd3; push_line(8'd3);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) line_req = 0;
            if (line_done === 1'b1 && done_k == 0) done_k = k;
            if (cpu_ack === 1'b1 && ack_k == 0) begin
                logic [15:0] exp_d;
                ack_k = k; cpu_req = 0;
                exp_d = cpu_q.pop_front();
                total_cnt++;
                if (cpu_rdata !== exp_d) $display("FAIL prio_data: got %h, required %h", cpu_rdata, exp_d);
                else pass_cnt++;
            end
        end
        cpu_req = 0;
        total_cnt++;
        if (done_k != 33 || ack_k != 37)
            $display("FAIL prio_cycles: got done=%0d ack=%0d, required done=33 ack=37", done_k, ack_k);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int done_k, ack_k;
        done_k = 0; ack_k = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0005; cpu_q.push_back(ref_val(13'h0005));
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1 && ack_k == 0) begin
                logic [15:0] exp_d;
                ack_k = k; cpu_req = 0;
                exp_d = cpu_q.pop_front();
                total_cnt++;
                if (cpu_rdata !== exp_d) $display("FAIL ovr_read_data: got %h, required %h", cpu_rdata, exp_d);
                else pass_cnt++;
            end
            if (k == 3) begin
                total_cnt++;
                if (overrun !== 1'b1 || line_busy !== 1'b1)
                    $display("FAIL ovr_set: got overrun=%b busy=%b, required 1 1", overrun, line_busy);
                else pass_cnt++;
            end
            if (line_done === 1'b1 && done_k == 0) done_k = k;
            if (k == 1) begin line_req = 1; line_num = 8'd7; end
            if (k == 2) begin line_num = 8'd9; push_line(8'd9); end
            if (k == 3) line_req = 0;
        end
        total_cnt++;
        if (done_k != 37 || ack_k != 3 || lb_q.size() != 0)
            $display("FAIL ovr_cycles: got done=%0d ack=%0d left=%0d, required 37 3 0",
                     done_k, ack_k, lb_q.size());
        else pass_cnt++;
        ovr_clr = 1;
        @(negedge clk);
        ovr_clr = 0;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b, required 0", overrun);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int done1, done2;
        bit gap;
        done1 = 0; done2 = 0; gap = 0;
        line_req = 1; line_num = 8'd255; push_line(8'd255);
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            if (k == 1) line_req = 0;
            if (k == 1 || k == 32) begin
                logic [12:0] exp_a;
                exp_a = (k == 1) ? 13'h1FE0 : 13'h1FFF;
                total_cnt++;
                if (mem_addr !== exp_a) $display("FAIL b2b_addr: got %h, required %h", mem_addr, exp_a);
                else pass_cnt++;
            end
            if (k <= 67 && line_busy !== 1'b1) gap = 1;
            if (line_done === 1'b1) begin
                if (done1 == 0) done1 = k;
                else if (done2 == 0) done2 = k;
            end
            if (k == 68) begin
                total_cnt++;
                if (line_busy !== 1'b0) $display("FAIL b2b_busy_end: got %b, required 0", line_busy);
                else pass_cnt++;
            end
            if (k == 10) begin line_req = 1; line_num = 8'd4; push_line(8'd4); end
            if (k == 11) line_req = 0;
        end
        total_cnt++;
        if (done1 != 33 || done2 != 67 || gap || lb_q.size() != 0)
            $display("FAIL b2b_cycles: got done1=%0d done2=%0d gap=%0d left=%0d, required 33 67 0 0",
                     done1, done2, gap, lb_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_fetch();
        int seen;
        line_req = 1; line_num = 8'd3; push_line(8'd3);
        @(negedge clk);
        line_req = 0;
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({lb_we, line_busy, line_done, mem_we, cpu_ack} !== 5'b0 || mem_addr !== 13'h0 ||
            cpu_rdata !== 16'h0 || lb_wdata !== 16'h0)
            $display("FAIL reset_async: got ctl=%b addr=%h rdata=%h, required all 0",
                     {lb_we, line_busy, line_done, mem_we, cpu_ack}, mem_addr, cpu_rdata);
        else pass_cnt++;
        lb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (line_done === 1'b1 || lb_we === 1'b1) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL reset_no_done: got %0d fetch events, required 0", seen);
        else pass_cnt++;

        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0005;
        @(negedge clk);
        #2 reset_n = 1'b0;
        cpu_req = 0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL reset_no_ack: got %0d acks, required 0", seen);
        else pass_cnt++;

        seen = 0;
        line_req = 1; line_num = 8'd1; push_line(8'd1);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1) line_req = 0;
            if (line_done === 1'b1 && seen == 0) seen = k;
        end
        total_cnt++;
        if (seen != 33 || lb_q.size() != 0)
            $display("FAIL reset_refetch: got done=%0d left=%0d, required 33 0", seen, lb_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_line_fetch();
        test_fetch_priority();
        test_overrun();
        test_back_to_back();
        test_reset_mid_fetch();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, required completion");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "timeout");
    end

endmodule
